// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the UltraScale+ reset sequencer.
// Holds the FSM state encoding, the lock-loss counter width and the default timing.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RELEASE,
        ST_RUN,
        ST_HOLD
    } state_e;

    localparam int LockLossW = 8;

    localparam int DefNumRst           = 3;
    localparam int DefLockStableCycles = 1024;
    localparam int DefGapCycles        = 16;
    localparam int DefHoldCycles       = 32;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for bringing asynchronous level signals into clk_i.
// Both stages reset to ResetValue so a fresh reset never reports a stale level.
module prim_flop_2sync #(
    parameter int               Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] r_meta;
    logic [Width-1:0] r_sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta <= ResetValue;
            r_sync <= ResetValue;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/rst_seq_xilusp.sv
// Reset sequencer: qualifies PLL lock, releases NumRst resets in order with a fixed gap,
// and re-asserts them on lock loss or software request while counting lock-loss events.
module rst_seq_xilusp
    import rst_seq_pkg::*;
#(
    parameter int NumRst           = DefNumRst,
    parameter int LockStableCycles = DefLockStableCycles,
    parameter int GapCycles        = DefGapCycles,
    parameter int HoldCycles       = DefHoldCycles
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 locked_i,
    input  logic                 sw_rst_req_i,
    output logic [NumRst-1:0]    rst_n_o,
    output logic                 seq_done_o,
    output logic [LockLossW-1:0] lock_loss_o
);

    localparam int CntMax = max3(LockStableCycles, GapCycles, HoldCycles);
    localparam int CntW   = $clog2(CntMax + 1);
    localparam int IdxW   = (NumRst > 1) ? $clog2(NumRst) : 1;

    // The counter is loaded with N-1 and the move happens on the edge that sees zero,
    // so each phase lasts exactly N edges.
    localparam logic [CntW-1:0] LoadStable = CntW'(LockStableCycles - 1);
    localparam logic [CntW-1:0] LoadGap    = CntW'(GapCycles - 1);
    localparam logic [CntW-1:0] LoadHold   = CntW'(HoldCycles - 1);
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(NumRst - 1);

    if (NumRst < 1) begin : g_chk_num_rst
        $error("NumRst must be >= 1");
    end
    if (LockStableCycles < 1) begin : g_chk_lock_stable
        $error("LockStableCycles must be >= 1");
    end
    if (GapCycles < 1) begin : g_chk_gap
        $error("GapCycles must be >= 1");
    end
    if (HoldCycles < 1) begin : g_chk_hold
        $error("HoldCycles must be >= 1");
    end

    logic                 w_locked_s;
    state_e               r_state;
    logic [CntW-1:0]      r_cnt;
    logic [IdxW-1:0]      r_idx;
    logic [NumRst-1:0]    r_rst_n;
    logic                 r_seq_done;
    logic [LockLossW-1:0] r_lock_loss;

    prim_flop_2sync #(
        .Width      (1),
        .ResetValue (1'b0)
    ) u_lock_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (locked_i),
        .q_o    (w_locked_s)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_WAIT_LOCK;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_rst_n     <= '0;
            r_seq_done  <= 1'b0;
            r_lock_loss <= '0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        r_cnt   <= LoadStable;
                        r_state <= ST_STABLE;
                    end
                end

                // Lock loss is ignored here: HOLD always runs to completion.
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_WAIT_LOCK;
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end

                // STABLE, RELEASE and RUN share the fault paths; lock loss beats sw request.
                default: begin
                    if (!w_locked_s) begin
                        r_rst_n    <= '0;
                        r_seq_done <= 1'b0;
                        r_state    <= ST_WAIT_LOCK;
                        if (r_state != ST_STABLE && r_lock_loss != '1) begin
                            r_lock_loss <= r_lock_loss + LockLossW'(1);
                        end
                    end else if (sw_rst_req_i) begin
                        r_rst_n    <= '0;
                        r_seq_done <= 1'b0;
                        r_cnt      <= LoadHold;
                        r_state    <= ST_HOLD;
                    end else if (r_state == ST_STABLE) begin
                        if (r_cnt == '0) begin
                            r_rst_n[0] <= 1'b1;
                            if (NumRst == 1) begin
                                r_seq_done <= 1'b1;
                                r_state    <= ST_RUN;
                            end else begin
                                r_idx   <= IdxW'(1);
                                r_cnt   <= LoadGap;
                                r_state <= ST_RELEASE;
                            end
                        end else begin
                            r_cnt <= r_cnt - CntW'(1);
                        end
                    end else if (r_state == ST_RELEASE) begin
                        if (r_cnt == '0) begin
                            r_rst_n[r_idx] <= 1'b1;
                            if (r_idx == LastIdx) begin
                                r_seq_done <= 1'b1;
                                r_state    <= ST_RUN;
                            end else begin
                                r_idx <= r_idx + IdxW'(1);
                                r_cnt <= LoadGap;
                            end
                        end else begin
                            r_cnt <= r_cnt - CntW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign rst_n_o     = r_rst_n;
    assign seq_done_o  = r_seq_done;
    assign lock_loss_o = r_lock_loss;

endmodule

// File: tb/tb_rst_seq_xilusp.sv
// Bench for rst_seq_xilusp: directed timing scenarios plus randomized lock/sw/reset
// traffic checked against an event-timestamp model of the release schedule.
module tb_rst_seq_xilusp;

    localparam int NumRst = 3;
    localparam int LStab  = 8;
    localparam int Gap    = 4;
    localparam int Hold   = 5;

    logic              clk_i        = 1'b0;
    logic              rst_ni       = 1'b1;
    logic              locked_i     = 1'b0;
    logic              sw_rst_req_i = 1'b0;
    logic [NumRst-1:0] rst_n_o;
    logic              seq_done_o;
    logic [7:0]        lock_loss_o;

    always #5 clk_i = ~clk_i;

    rst_seq_xilusp #(
        .NumRst           (NumRst),
        .LockStableCycles (LStab),
        .GapCycles        (Gap),
        .HoldCycles       (Hold)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .locked_i     (locked_i),
        .sw_rst_req_i (sw_rst_req_i),
        .rst_n_o      (rst_n_o),
        .seq_done_o   (seq_done_o),
        .lock_loss_o  (lock_loss_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a run starts at the edge where the synchronised lock is first seen in a
    // waiting phase; bit k is released LStab+k*Gap edges later unless disrupted.
    int m_edge = 0;
    bit m_s1, m_s2;
    bit m_active;
    int m_start;
    int m_wait_from;
    int m_ll;

    int                rise_edge[NumRst];
    int                done_rise;
    logic [NumRst-1:0] prev_rst;
    logic              prev_done;

    task automatic model_reset();
        m_s1        = 1'b0;
        m_s2        = 1'b0;
        m_active    = 1'b0;
        m_wait_from = 0;
        m_ll        = 0;
        prev_rst    = '0;
        prev_done   = 1'b0;
        done_rise   = -1;
        for (int k = 0; k < NumRst; k++) rise_edge[k] = -1;
    endtask

    task automatic model_edge(input bit lk, input bit sw);
        bit ls;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        if (m_active) begin
            if (!ls) begin
                if (m_edge > m_start + LStab && m_ll < 255) m_ll++;
                m_active    = 1'b0;
                m_wait_from = m_edge + 1;
            end else if (sw) begin
                m_active    = 1'b0;
                m_wait_from = m_edge + Hold + 1;
            end
        end else if (m_edge >= m_wait_from && ls) begin
            m_active = 1'b1;
            m_start  = m_edge;
        end
    endtask

    function automatic logic [NumRst-1:0] exp_rst();
        logic [NumRst-1:0] r;
        for (int k = 0; k < NumRst; k++)
            r[k] = m_active && (m_edge >= m_start + LStab + Gap * k);
        return r;
    endfunction

    function automatic logic exp_done();
        return m_active && (m_edge >= m_start + LStab + Gap * (NumRst - 1));
    endfunction

    task automatic step(input bit lk, input bit sw);
        @(negedge clk_i);
        locked_i     = lk;
        sw_rst_req_i = sw;
        @(posedge clk_i);
        m_edge++;
        model_edge(lk, sw);
        #1;
        check_eq("rst_n", 32'(rst_n_o), 32'(exp_rst()));
        check_eq("seq_done", 32'(seq_done_o), 32'(exp_done()));
        check_eq("lock_loss", 32'(lock_loss_o), 32'(m_ll));
        for (int k = 0; k < NumRst; k++)
            if (rst_n_o[k] && !prev_rst[k]) rise_edge[k] = m_edge;
        if (seq_done_o && !prev_done) done_rise = m_edge;
        prev_rst  = rst_n_o;
        prev_done = seq_done_o;
    endtask

    // Asserts rst_ni between edges and checks outputs clear without waiting for a clock.
    task automatic apply_reset(input bit lk);
        @(negedge clk_i);
        locked_i     = lk;
        sw_rst_req_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("async_rst_n", 32'(rst_n_o), 32'd0);
        check_eq("async_done", 32'(seq_done_o), 32'd0);
        check_eq("async_ll", 32'(lock_loss_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        model_reset();
    endtask

    int t0;

    initial begin
        model_reset();

        // Power-up: lock seen at edge t0 -> bits at +10/+14/+18.
        apply_reset(1'b0);
        t0 = m_edge + 1;
        repeat (22) step(1'b1, 1'b0);
        check_eq("pu_rise0", 32'(rise_edge[0] - t0), 32'd10);
        check_eq("pu_rise1", 32'(rise_edge[1] - t0), 32'd14);
        check_eq("pu_rise2", 32'(rise_edge[2] - t0), 32'd18);
        check_eq("pu_done", 32'(done_rise - t0), 32'd18);
        check_eq("pu_ll", 32'(lock_loss_o), 32'd0);

        // Lock loss in RUN: outputs clear on the third edge after the drop.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_eq("ll_pre", 32'(rst_n_o), 32'd7);
        step(1'b0, 1'b0);
        check_eq("ll_drop", 32'(rst_n_o), 32'd0);
        check_eq("ll_cnt", 32'(lock_loss_o), 32'd1);
        t0 = m_edge + 1;
        repeat (22) step(1'b1, 1'b0);
        check_eq("relock_rise0", 32'(rise_edge[0] - t0), 32'd10);
        check_eq("relock_done", 32'(done_rise - t0), 32'd18);

        // Software request in RUN: HOLD then requalify, bit 0 at +14.
        t0 = m_edge + 1;
        step(1'b1, 1'b1);
        check_eq("sw_drop", 32'(rst_n_o), 32'd0);
        repeat (25) step(1'b1, 1'b0);
        check_eq("sw_rise0", 32'(rise_edge[0] - t0), 32'd14);
        check_eq("sw_ll", 32'(lock_loss_o), 32'd1);

        // Lock loss and sw request on the same edge: counted, no HOLD.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check_eq("sim_ll", 32'(lock_loss_o), 32'd2);
        t0 = m_edge + 1;
        repeat (22) step(1'b1, 1'b0);
        check_eq("sim_rise0", 32'(rise_edge[0] - t0), 32'd10);

        // Glitch during qualification restarts the count, not counted.
        apply_reset(1'b0);
        repeat (6) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        t0 = m_edge + 1;
        repeat (22) step(1'b1, 1'b0);
        check_eq("glitch_rise0", 32'(rise_edge[0] - t0), 32'd10);
        check_eq("glitch_ll", 32'(lock_loss_o), 32'd0);

        // Async reset during RELEASE, then a clean restart from bit 0.
        apply_reset(1'b1);
        t0 = m_edge + 1;
        repeat (13) step(1'b1, 1'b0);
        check_eq("rel_mid", 32'(rst_n_o), 32'd1);
        apply_reset(1'b1);
        t0 = m_edge + 1;
        repeat (22) step(1'b1, 1'b0);
        check_eq("rst_rise0", 32'(rise_edge[0] - t0), 32'd10);
        check_eq("rst_rise2", 32'(rise_edge[2] - t0), 32'd18);

        // 300 lock-loss events in RUN saturate the counter.
        for (int i = 0; i < 300; i++) begin
            repeat (22) step(1'b1, 1'b0);
            repeat (3) step(1'b0, 1'b0);
        end
        check_eq("sat_ll", 32'(lock_loss_o), 32'd255);

        // Randomized lock, sw and reset traffic against the model.
        begin
            bit lk;
            lk = 1'b1;
            for (int i = 0; i < 5000; i++) begin
                if (lk ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 7) == 0)) lk = !lk;
                if ($urandom_range(0, 799) == 0) apply_reset(lk);
                step(lk, $urandom_range(0, 59) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
